// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and constants for the serial transmit arbiter and its helpers.
package serial_tx_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W = 3;
  localparam logic [7:0] DEFAULT_TAG_BASE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH
  } arbState;

  typedef enum logic {
    TAG,
    DATA
  } txPhase;

  function automatic logic [ID_W-1:0] nextId(input logic [ID_W-1:0] id, input int numReq);
    return (int'(id) == numReq - 1) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester and transmitter side signals of the serial transmit arbiter.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import serial_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_LAST;
  logic [NUM_REQ-1:0]   REQ_ACK;
  logic [7:0]           TX_DATA;
  logic                 TX_SEND;
  logic                 TX_READY;
  logic [ID_W-1:0]      GRANT_ID;
  logic                 BUSY;
  logic                 ERR_TIMEOUT;

  modport master (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
    output REQ_ACK, TX_DATA, TX_SEND, GRANT_ID, BUSY, ERR_TIMEOUT
  );

  modport slave (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
    input  REQ_ACK, TX_DATA, TX_SEND, GRANT_ID, BUSY, ERR_TIMEOUT
  );

endinterface

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, searching cyclically.
module rr_priority_pick
  import serial_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               anyValid
);

  logic [MAX_REQ-1:0] reqPad;

  assign reqPad = MAX_REQ'(reqVec);

  // Walk offsets from the far end so the closest hit to ptr is the one left standing.
  always_comb begin
    logic [ID_W:0] slot;
    slot     = '0;
    winner   = '0;
    anyValid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      slot = {1'b0, ptr} + (ID_W + 1)'(i);
      if (slot >= (ID_W + 1)'(NUM_REQ)) begin
        slot = slot - (ID_W + 1)'(NUM_REQ);
      end
      if (reqPad[slot[ID_W-1:0]]) begin
        winner   = slot[ID_W-1:0];
        anyValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one byte transmitter among NUM_REQ message producers,
// with optional per-message tag byte and a watchdog on the transmitter handshake.
//
//   state     | meaning
//   IDLE      | no message in progress, arbitrate on REQ_VALID
//   ISSUE     | grant held, waiting for TX_READY (and REQ_VALID in DATA phase) to send a byte
//   WAIT_LOW  | byte sent, waiting for TX_READY to fall; watchdog running
//   WAIT_HIGH | transmitter busy, waiting for TX_READY to rise again
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ        = 4,
  parameter int         TAG_EN         = 1,
  parameter logic [7:0] TAG_BASE       = DEFAULT_TAG_BASE,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input logic CLK,
  input logic RESET_N,
  serial_tx_arbiter_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arbState              state, stateN;
  txPhase               phase, phaseN;
  logic [ID_W-1:0]      grantId, grantN;
  logic [ID_W-1:0]      rrPtr, ptrN;
  logic                 lastByte, lastN;
  logic [WD_W-1:0]      wdog, wdogN;
  logic [7:0]           txData, txDataN;
  logic                 txSend, txSendN;
  logic [NUM_REQ-1:0]   reqAck, ackN;
  logic                 busy, busyN;
  logic                 errTimeout, errN;

  logic [MAX_REQ-1:0]   validPad;
  logic [MAX_REQ-1:0]   lastPad;
  logic [8*MAX_REQ-1:0] dataPad;
  logic [7:0]           selData;
  logic [ID_W-1:0]      winner;
  logic                 anyValid;

  assign validPad = MAX_REQ'(bus.REQ_VALID);
  assign lastPad  = MAX_REQ'(bus.REQ_LAST);
  assign dataPad  = (8 * MAX_REQ)'(bus.REQ_DATA);
  assign selData  = dataPad[{grantId, 3'b000} +: 8];

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) uPick (
    .reqVec   (bus.REQ_VALID),
    .ptr      (rrPtr),
    .winner   (winner),
    .anyValid (anyValid)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      phase      <= TAG;
      grantId    <= '0;
      rrPtr      <= '0;
      lastByte   <= 1'b0;
      wdog       <= '0;
      txData     <= '0;
      txSend     <= 1'b0;
      reqAck     <= '0;
      busy       <= 1'b0;
      errTimeout <= 1'b0;
    end else begin
      state      <= stateN;
      phase      <= phaseN;
      grantId    <= grantN;
      rrPtr      <= ptrN;
      lastByte   <= lastN;
      wdog       <= wdogN;
      txData     <= txDataN;
      txSend     <= txSendN;
      reqAck     <= ackN;
      busy       <= busyN;
      errTimeout <= errN;
    end
  end

  always_comb begin
    stateN  = state;
    phaseN  = phase;
    grantN  = grantId;
    ptrN    = rrPtr;
    lastN   = lastByte;
    wdogN   = wdog;
    txDataN = txData;
    txSendN = 1'b0;
    ackN    = '0;
    busyN   = busy;
    errN    = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          grantN = winner;
          busyN  = 1'b1;
          phaseN = (TAG_EN != 0) ? TAG : DATA;
          stateN = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.TX_READY) begin
          if (phase == TAG) begin
            txDataN = TAG_BASE + 8'(grantId);
            txSendN = 1'b1;
            wdogN   = '0;
            stateN  = WAIT_LOW;
          end else if (validPad[grantId]) begin
            txDataN = selData;
            ackN    = NUM_REQ'(MAX_REQ'(1) << grantId);
            lastN   = lastPad[grantId];
            txSendN = 1'b1;
            wdogN   = '0;
            stateN  = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (!bus.TX_READY) begin
          stateN = WAIT_HIGH;
        end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // The count reaches TIMEOUT_CYCLES on this edge: give up on the message.
          errN   = 1'b1;
          busyN  = 1'b0;
          ptrN   = nextId(grantId, NUM_REQ);
          stateN = IDLE;
        end else begin
          wdogN = wdog + WD_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (bus.TX_READY) begin
          if (phase == TAG) begin
            phaseN = DATA;
            stateN = ISSUE;
          end else if (!lastByte) begin
            stateN = ISSUE;
          end else begin
            ptrN   = nextId(grantId, NUM_REQ);
            busyN  = 1'b0;
            stateN = IDLE;
          end
        end
      end
      default: stateN = IDLE;
    endcase
  end

  assign bus.TX_DATA     = txData;
  assign bus.TX_SEND     = txSend;
  assign bus.REQ_ACK     = reqAck;
  assign bus.GRANT_ID    = grantId;
  assign bus.BUSY        = busy;
  assign bus.ERR_TIMEOUT = errTimeout;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed and randomized checks of serial_tx_arbiter against a message-level model
// of round-robin arbitration with tag prefixing.
module tb_serial_tx_arbiter;
  import serial_tx_arbiter_pkg::*;

  localparam int         NREQ  = 4;
  localparam int         TOUT  = 16;
  localparam logic [7:0] TBASE = 8'hF0;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  serial_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  serial_tx_arbiter #(
    .NUM_REQ(NREQ), .TAG_EN(1), .TAG_BASE(TBASE), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  int nChecks = 0;
  int nFail = 0;

  logic [8:0] rq[NREQ][$];
  logic [8:0] mq[NREQ][$];
  logic [7:0] txLog[$];
  logic [7:0] expQ[$];
  int ackCnt[NREQ];
  int holdOff[NREQ];
  int stallArm[NREQ];
  int dropDelay = 1;
  int highDelay = 3;
  bit stuck = 1'b0;
  int dropCnt = 0, highCnt = 0;
  int cyc = 0, lastSendCyc = 0, errCyc = 0, errCnt = 0, protoErr = 0;
  logic busyAtErr = 1'b1;
  int mPtr = 0;

  // Environment: monitor, transmitter model and requesters, all on the falling edge.
  always @(negedge CLK) begin
    cyc++;
    if (!RESET_N) begin
      bus.TX_READY = 1'b1;
      dropCnt = 0;
      highCnt = 0;
    end else begin
      if (bus.TX_SEND) begin
        txLog.push_back(bus.TX_DATA);
        lastSendCyc = cyc;
        if (bus.TX_READY !== 1'b1) protoErr++;
      end
      if (bus.REQ_ACK != '0) begin
        if (!bus.TX_SEND || bus.REQ_ACK != NREQ'(1 << bus.GRANT_ID)) protoErr++;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.REQ_ACK[i]) begin
            ackCnt[i]++;
            if (rq[i].size() == 0 || bus.TX_DATA !== rq[i][0][7:0]) protoErr++;
            if (rq[i].size() != 0) void'(rq[i].pop_front());
            if (stallArm[i] > 0) begin
              holdOff[i] = stallArm[i];
              stallArm[i] = 0;
            end
          end
        end
      end
      if (bus.ERR_TIMEOUT) begin
        errCyc = cyc;
        errCnt++;
        busyAtErr = bus.BUSY;
      end
      if (bus.TX_SEND && !stuck) begin
        dropCnt = dropDelay;
      end else if (dropCnt > 0) begin
        dropCnt--;
        if (dropCnt == 0) begin
          bus.TX_READY = 1'b0;
          highCnt = highDelay;
        end
      end else if (highCnt > 0) begin
        highCnt--;
        if (highCnt == 0) bus.TX_READY = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (holdOff[i] > 0) begin
        holdOff[i]--;
        bus.REQ_VALID[i] = 1'b0;
      end else begin
        bus.REQ_VALID[i] = (rq[i].size() != 0);
      end
      if (rq[i].size() != 0) begin
        bus.REQ_DATA[8*i +: 8] = rq[i][0][7:0];
        bus.REQ_LAST[i] = rq[i][0][8];
      end else begin
        bus.REQ_DATA[8*i +: 8] = 8'h00;
        bus.REQ_LAST[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic loadByte(input int id, input logic [7:0] b, input bit last);
    rq[id].push_back({last, b});
    mq[id].push_back({last, b});
  endtask

  task automatic loadMsg(input int id, input int len);
    for (int k = 0; k < len; k++) loadByte(id, 8'($urandom_range(0, 255)), k == len - 1);
  endtask

  // Whole messages in round-robin order from mPtr; each message prefixed by its tag.
  task automatic modelRun();
    logic [8:0] w;
    int id;
    while (1) begin
      id = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (id < 0 && mq[(mPtr + k) % NREQ].size() != 0) id = (mPtr + k) % NREQ;
      end
      if (id < 0) break;
      expQ.push_back(TBASE + 8'(id));
      do begin
        w = mq[id].pop_front();
        expQ.push_back(w[7:0]);
      end while (!w[8]);
      mPtr = (id + 1) % NREQ;
    end
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (n < 4000 && !(allEmpty() && bus.BUSY === 1'b0 && bus.TX_READY === 1'b1)) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic compareLog(input string tag);
    chk({tag, "_byte_count"}, 32'(txLog.size()), 32'(expQ.size()));
    for (int i = 0; i < txLog.size() && i < expQ.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(txLog[i]), 32'(expQ[i]));
    txLog.delete();
    expQ.delete();
  endtask

  task automatic waitBusy(input string tag);
    int n = 0;
    while (n < 200 && bus.BUSY !== 1'b1) begin
      tick();
      n++;
    end
    chk({tag, "_busy_seen"}, 32'(n < 200), 32'd1);
  endtask

  task automatic checkOutputsZero(input string tag);
    chk({tag, "_tx_data"}, 32'(bus.TX_DATA), 32'd0);
    chk({tag, "_tx_send"}, 32'(bus.TX_SEND), 32'd0);
    chk({tag, "_req_ack"}, 32'(bus.REQ_ACK), 32'd0);
    chk({tag, "_grant_id"}, 32'(bus.GRANT_ID), 32'd0);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_err"}, 32'(bus.ERR_TIMEOUT), 32'd0);
  endtask

  task automatic doReset();
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    tick(2);
    mPtr = 0;
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    int a0, e0, n;

    RESET_N = 1'b0;
    tick(2);
    checkOutputsZero("reset");
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    tick(2);

    // Single tagged message from requester 2, slow transmitter.
    dropDelay = 1;
    highDelay = 20;
    loadByte(2, 8'h41, 1'b1);
    modelRun();
    waitBusy("t1");
    chk("t1_grant", 32'(bus.GRANT_ID), 32'd2);
    n = 0;
    while (n < 300 && ackCnt[2] == 0) begin tick(); n++; end
    chk("t1_ack_seen", 32'(n < 300), 32'd1);
    tick(5);
    chk("t1_data_hold", 32'(bus.TX_DATA), 32'h41);
    chk("t1_send_low", 32'(bus.TX_SEND), 32'd0);
    drain("t1");
    compareLog("t1");
    chk("t1_ack_count", 32'(ackCnt[2]), 32'd1);
    chk("t1_busy_clear", 32'(bus.BUSY), 32'd0);

    // Pointer sits at 3 now: requester 3 must beat requester 1.
    dropDelay = 2;
    highDelay = 3;
    loadMsg(1, 1);
    loadMsg(3, 1);
    modelRun();
    waitBusy("t1b");
    chk("t1b_grant", 32'(bus.GRANT_ID), 32'd3);
    drain("t1b");
    compareLog("t1b");

    // Contention from pointer 0: order 0,1,2,3,0.
    doReset();
    for (int i = 0; i < NREQ; i++) loadMsg(i, 1);
    loadMsg(0, 1);
    modelRun();
    drain("t2");
    compareLog("t2");

    // Three-byte message keeps the grant against a waiting requester.
    loadMsg(1, 3);
    loadMsg(0, 1);
    modelRun();
    drain("t3");
    compareLog("t3");

    // Requester 3 stalls after its first data byte.
    a0 = ackCnt[3];
    stallArm[3] = 50;
    loadMsg(3, 2);
    modelRun();
    n = 0;
    while (n < 200 && ackCnt[3] == a0) begin tick(); n++; end
    chk("t4_first_ack", 32'(n < 200), 32'd1);
    tick(15);
    for (int k = 0; k < 6; k++) begin
      chk("t4_stall_send", 32'(bus.TX_SEND), 32'd0);
      chk("t4_stall_grant", 32'(bus.GRANT_ID), 32'd3);
      chk("t4_stall_busy", 32'(bus.BUSY), 32'd1);
      tick(2);
    end
    drain("t4");
    compareLog("t4");
    chk("t4_ack_count", 32'(ackCnt[3]), 32'(a0 + 2));

    // Put the pointer at 1, then let requester 1's tag time out.
    loadMsg(0, 1);
    modelRun();
    drain("t5a");
    compareLog("t5a");
    e0 = errCnt;
    stuck = 1'b1;
    loadMsg(0, 1);
    loadMsg(1, 1);
    expQ.push_back(TBASE + 8'd1);
    mPtr = 2;
    n = 0;
    while (n < 200 && errCnt == e0) begin tick(); n++; end
    stuck = 1'b0;
    chk("t5_err_seen", 32'(n < 200), 32'd1);
    chk("t5_err_latency", 32'(errCyc - lastSendCyc), 32'(TOUT));
    chk("t5_busy_at_err", 32'(busyAtErr), 32'd0);
    modelRun();
    drain("t5");
    compareLog("t5");
    chk("t5_err_pulses", 32'(errCnt), 32'(e0 + 1));

    // Async reset while waiting for READY to rise after requester 3's tag.
    dropDelay = 1;
    highDelay = 40;
    loadMsg(1, 1);
    loadMsg(3, 1);
    expQ.push_back(TBASE + 8'd3);
    waitBusy("t6");
    chk("t6_grant", 32'(bus.GRANT_ID), 32'd3);
    n = 0;
    while (n < 100 && bus.TX_READY !== 1'b0) begin tick(); n++; end
    chk("t6_ready_low", 32'(n < 100), 32'd1);
    tick(2);
    chk("t6_busy_before", 32'(bus.BUSY), 32'd1);
    #3 RESET_N = 1'b0;
    #1;
    checkOutputsZero("t6_async");
    tick(3);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    mPtr = 0;
    modelRun();
    drain("t6");
    compareLog("t6");

    // Random message mixes and transmitter timing.
    for (int r = 0; r < 6; r++) begin
      dropDelay = $urandom_range(1, 3);
      highDelay = $urandom_range(1, 6);
      for (int i = 0; i < NREQ; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) loadMsg(i, $urandom_range(1, 3));
      end
      modelRun();
      drain($sformatf("rnd%0d", r));
      compareLog($sformatf("rnd%0d", r));
    end

    chk("protocol_violations", 32'(protoErr), 32'd0);
    chk("total_timeouts", 32'(errCnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one SerialTransmitter byte interface among NUM_REQ requesters using round-robin arbitration.
- Messages are multi-byte and terminated by REQ_LAST; the grant is held until the message ends.
- Optionally prefixes each message with a tag byte (TAG_BASE + requester id) so the host can demultiplex.
- Sits between the command/status producers and SerialTransmitter: drives its IN_DATA/IN_SEND and watches OUT_STATUS_READY.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_EN, 1, 1 = send a tag byte before the first byte of each message.
- TAG_BASE, 8'hF0, tag byte value = TAG_BASE + granted id (8-bit wrap).
- TIMEOUT_CYCLES, 16, max cycles to wait for TX_READY to fall after TX_SEND.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  NUM_REQ  requester i has a byte pending.
- REQ_DATA  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- REQ_LAST  in  NUM_REQ  byte of requester i is the last of its message.
- REQ_ACK  out  NUM_REQ  one-cycle pulse: requester i's byte was consumed.
- TX_DATA  out  8  to transmitter IN_DATA.
- TX_SEND  out  1  to transmitter IN_SEND.
- TX_READY  in  1  from transmitter OUT_STATUS_READY.
- GRANT_ID  out  3  id currently holding the grant.
- BUSY  out  1  a message is in progress.
- ERR_TIMEOUT  out  1  one-cycle pulse: transmitter did not respond.

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE, rr pointer 0, REQ_ACK 0, TX_SEND 0, TX_DATA 0, GRANT_ID 0, BUSY 0, ERR_TIMEOUT 0. All outputs are registered.
- Reset mid-transfer aborts the message. No ACK is issued for the byte in flight.
- IDLE:
  - If any REQ_VALID, grant the first valid id at or after the pointer, searching cyclically.
  - Latch the id into GRANT_ID and set BUSY.
  - Go to ISSUE with phase = TAG if TAG_EN, else DATA.
- ISSUE, entered only when TX_READY = 1:
  - Phase TAG: TX_DATA <= TAG_BASE + id.
  - Phase DATA: wait for REQ_VALID[id]. Then TX_DATA <= REQ_DATA[id], REQ_ACK[id] pulses in the same cycle, and REQ_LAST[id] is latched.
  - TX_SEND pulses exactly one cycle, in the same cycle as the TX_DATA update. Go to WAIT_LOW and start the watchdog.
- WAIT_LOW:
  - Wait for TX_READY = 0 and go to WAIT_HIGH.
  - If TIMEOUT_CYCLES elapse first: pulse ERR_TIMEOUT, clear BUSY, advance the pointer to id+1, return to IDLE.
- WAIT_HIGH:
  - Wait for TX_READY = 1. TX_DATA holds stable throughout.
  - Then:
    - Phase TAG → phase DATA, go to ISSUE.
    - Phase DATA, last = 0 → go to ISSUE; the grant is held and no tag is sent.
    - Phase DATA, last = 1 → pointer <= (id+1) mod NUM_REQ, BUSY <= 0, go to IDLE.
- Arbitration:
  - Rotation happens only at message end or timeout.
  - A requester dropping REQ_VALID mid-message keeps the grant. The arbiter waits in ISSUE indefinitely.
  - Requests asserting while BUSY wait for the next IDLE.
  - Back-to-back: after IDLE there is one cycle of arbitration before ISSUE.
- REQ_VALID is sampled only for the granted id. REQ_DATA and REQ_LAST must be stable while REQ_VALID is high and until ACK.
- TX_SEND is never asserted while TX_READY = 0.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). Timeout fires on the cycle the count reaches TIMEOUT_CYCLES.

Decomposition:
- Shared package/header: state encodings (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH), phase encodings (TAG, DATA), default TAG_BASE.
- One sub-module, rr_priority_pick:
  - Inputs: request vector and pointer.
  - Outputs: winner id and any-valid.
  - Purely combinational; reusable by later arbiters.

Test Plan:
1. Single message, TAG_EN=1. Requester 2 sends 8'h41 with LAST=1; the transmitter model drops READY 1 cycle after SEND and raises it 20 cycles later → TX bytes F2 then 41, one REQ_ACK[2] pulse, BUSY back to 0, next grant starts from id 3.
2. Contention. All 4 requesters valid with single-byte messages, pointer 0 → grant order 0,1,2,3,0. Tags F0,F1,F2,F3 precede data.
3. Multi-byte lock. Requester 1 sends 3 bytes (LAST on the 3rd) while requester 0 is valid → bytes F1,b0,b1,b2, then F0. No interleaving.
4. Stall mid-message. Requester 3 drops VALID for 50 cycles after byte 1 → the arbiter idles in ISSUE with TX_SEND=0 and GRANT_ID=3, then resumes without a tag.
5. Timeout. TX_READY is stuck at 1 after SEND, TIMEOUT_CYCLES=16 → ERR_TIMEOUT pulses 16 cycles after SEND, BUSY=0, pointer advances.
6. Async reset asserted during WAIT_HIGH → all outputs 0 immediately. After release, a pending request is granted starting from id 0.
